// File: rtl/ini_req_arbiter.sv
// ini_req_arbiter
//   Round-robin arbiter sharing one Ini injection port among NREQ local
//   requesters. One packet is outstanding at a time: a request is granted
//   in IDLE, held on the Ini port in ISSUE until accepted, and the 1-bit
//   completion response is routed back to its originator from WAIT_RESP.
//   A requester may keep the grant for up to MAX_BURST consecutive packets
//   before the pointer is forced past it.
//
// Ports
//   CLK, RESET         clock (rising edge) and synchronous active-high reset
//   req_valid/ready    per-requester request / one-hot combinational accept
//   req_addr/req_data  packed per-requester address and payload
//   out_valid/ready    packet handshake towards Ini
//   out_addr/data/src  registered packet fields and granted requester index
//   in_resp_valid/bit  Ini completion strobe and status
//   resp_valid/bit     one-hot one-cycle response strobe and status copy
//   proto_err          sticky: response seen outside WAIT_RESP
//   timeout_err        sticky: no response within TIMEOUT cycles
module ini_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(NREQ)-1:0]   out_src,
  input  logic                      in_resp_valid,
  input  logic                      in_resp_bit,
  output logic [NREQ-1:0]           resp_valid,
  output logic                      resp_bit,
  output logic                      proto_err,
  output logic                      timeout_err
);

  localparam int SRC_W   = $clog2(NREQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int TCNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_r;
  logic [SRC_W-1:0]    rr_ptr_r;
  logic [BURST_W-1:0]  burst_cnt_r;
  logic [TCNT_W-1:0]   tcnt_r;

  logic                sel_found_s;
  logic [SRC_W-1:0]    sel_idx_s;
  logic [SRC_W-1:0]    cand_s;
  logic [BURST_W-1:0]  burst_inc_s;
  logic                burst_done_s;
  logic [SRC_W-1:0]    src_next_s;

  // Scan requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      // NREQ is a power of two, so the SRC_W-bit add wraps modulo NREQ.
      cand_s = rr_ptr_r + SRC_W'(k);
      if (!sel_found_s && req_valid[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Burst bookkeeping and the rotated pointer value used on completion.
  always_comb begin
    burst_inc_s  = burst_cnt_r + BURST_W'(1'b1);
    burst_done_s = (burst_inc_s == BURST_W'(MAX_BURST));
    src_next_s   = out_src + SRC_W'(1'b1);
  end

  // Accept strobe: only the selected requester, only in IDLE, never in reset.
  always_comb begin
    req_ready = '0;
    if (!RESET && (state_r == ST_IDLE) && sel_found_s) begin
      req_ready[sel_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Arbitration state machine with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
      tcnt_r      <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_src     <= '0;
      resp_valid  <= '0;
      resp_bit    <= 1'b0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (state_r)
        ST_IDLE: begin
          if (in_resp_valid) begin
            proto_err <= 1'b1;
          end
          if (sel_found_s) begin
            out_addr  <= req_addr[sel_idx_s*ADDR_W +: ADDR_W];
            out_data  <= req_data[sel_idx_s*DATA_W +: DATA_W];
            out_src   <= sel_idx_s;
            out_valid <= 1'b1;
            // out_src still holds the previously granted index here.
            if (sel_idx_s != out_src) begin
              burst_cnt_r <= '0;
            end
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (in_resp_valid) begin
            proto_err <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            tcnt_r    <= '0;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response on the final timeout cycle still wins.
          if (in_resp_valid) begin
            resp_valid[out_src] <= 1'b1;
            resp_bit            <= in_resp_bit;
            state_r             <= ST_IDLE;
            if (burst_done_s) begin
              rr_ptr_r    <= src_next_s;
              burst_cnt_r <= '0;
            end else begin
              rr_ptr_r    <= out_src;
              burst_cnt_r <= burst_inc_s;
            end
          end else if (tcnt_r == TCNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            rr_ptr_r    <= src_next_s;
            burst_cnt_r <= '0;
            state_r     <= ST_IDLE;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1'b1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ini_req_arbiter.sv
// tb_ini_req_arbiter
//   Randomized bench for ini_req_arbiter. A transaction-level reference
//   model (grant pick by modular scan, burst/rotation bookkeeping, wait
//   counter) predicts every grant and response; predictions go into
//   queues that a separate monitor pops after each clock edge.
module tb_ini_req_arbiter;

  localparam int NREQ      = 4;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 2;
  localparam int TIMEOUT   = 64;
  localparam int SRC_W     = 2;
  localparam int AW_ALL    = NREQ * ADDR_W;
  localparam int DW_ALL    = NREQ * DATA_W;

  logic                   CLK = 1'b0;
  logic                   RESET = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [AW_ALL-1:0]      req_addr = '0;
  logic [DW_ALL-1:0]      req_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   in_resp_valid = 1'b0;
  logic                   in_resp_bit = 1'b0;
  logic [NREQ-1:0]        resp_valid;
  logic                   resp_bit;
  logic                   proto_err;
  logic                   timeout_err;

  ini_req_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_src(out_src),
    .in_resp_valid(in_resp_valid), .in_resp_bit(in_resp_bit),
    .resp_valid(resp_valid), .resp_bit(resp_bit),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } grant_t;

  typedef struct {
    int   src;
    logic rbit;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (post-edge view).
  int m_rr = 0, m_burst = 0, m_last = 0, m_wait = 0, m_target = 0;
  bit m_busy = 1'b0, m_sent = 1'b0, m_proto = 1'b0, m_tmo = 1'b0;

  // Stimulus knobs.
  bit k_full = 1'b0, k_proto = 1'b0, k_force_resp = 1'b0;
  int k_valid_pct = 50, k_ready_pct = 50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int choose_target();
    int r;
    if (k_full) return 0;
    r = $urandom_range(0, 9);
    if (r <= 6) return $urandom_range(0, 3);
    if (r == 7) return TIMEOUT - 1;   // response on the last allowed cycle
    if (r == 8) return TIMEOUT + 10;  // never answered -> timeout
    return $urandom_range(4, 20);
  endfunction

  // Effect of the coming clock edge on the model, given the driven inputs.
  task automatic model_step();
    int g;
    resp_t r;
    grant_t gr;
    if (RESET) begin
      m_rr = 0; m_burst = 0; m_last = 0; m_wait = 0;
      m_busy = 1'b0; m_sent = 1'b0; m_proto = 1'b0; m_tmo = 1'b0;
    end else if (!m_busy) begin
      if (in_resp_valid) m_proto = 1'b1;
      g = pick(req_valid, m_rr);
      if (g >= 0) begin
        gr.src  = g;
        gr.addr = req_addr[g*ADDR_W +: ADDR_W];
        gr.data = req_data[g*DATA_W +: DATA_W];
        grant_q.push_back(gr);
        if (g != m_last) m_burst = 0;
        m_last = g;
        m_busy = 1'b1;
        m_sent = 1'b0;
      end
    end else if (!m_sent) begin
      if (in_resp_valid) m_proto = 1'b1;
      if (out_ready) begin
        m_sent   = 1'b1;
        m_wait   = 0;
        m_target = choose_target();
      end
    end else begin
      if (in_resp_valid) begin
        r.src  = m_last;
        r.rbit = in_resp_bit;
        resp_q.push_back(r);
        if (m_burst + 1 == MAX_BURST) begin
          m_rr = (m_last + 1) % NREQ;
          m_burst = 0;
        end else begin
          m_rr = m_last;
          m_burst = m_burst + 1;
        end
        m_busy = 1'b0;
      end else if (m_wait == TIMEOUT - 1) begin
        m_rr = (m_last + 1) % NREQ;
        m_burst = 0;
        m_tmo = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_wait = m_wait + 1;
      end
    end
  endtask

  // One clock of stimulus: drive inputs, check req_ready, advance model.
  task automatic do_cycle(input bit rst);
    logic [NREQ-1:0] exp_ready;
    int g;
    @(negedge CLK);
    RESET = rst;
    for (int i = 0; i < NREQ; i++)
      req_valid[i] = k_full ? 1'b1 : ($urandom_range(0, 99) < k_valid_pct);
    req_addr    = AW_ALL'($urandom);
    req_data    = DW_ALL'($urandom);
    out_ready   = k_full ? 1'b1 : ($urandom_range(0, 99) < k_ready_pct);
    in_resp_bit = 1'($urandom);
    if (rst) in_resp_valid = 1'b0;
    else if (m_busy && m_sent) in_resp_valid = (m_wait == m_target);
    else if (k_force_resp) in_resp_valid = 1'b1;
    else if (k_proto) in_resp_valid = ($urandom_range(0, 24) == 0);
    else in_resp_valid = 1'b0;
    #1;
    exp_ready = '0;
    g = pick(req_valid, m_rr);
    if (!rst && !m_busy && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    model_step();
  endtask

  // Monitor: compares DUT outputs with the model one step after each edge.
  initial begin
    grant_t cur;
    resp_t  r;
    logic [NREQ-1:0] exp_rv;
    cur.src = 0; cur.addr = '0; cur.data = '0;
    forever begin
      @(posedge CLK);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_busy && !m_sent));
      if (grant_q.size() > 0) cur = grant_q.pop_front();
      if (out_valid) begin
        chk("out_src", 32'(out_src), 32'(cur.src));
        chk("out_addr", 32'(out_addr), 32'(cur.addr));
        chk("out_data", 32'(out_data), 32'(cur.data));
      end
      exp_rv = '0;
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        exp_rv[r.src] = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_bit", 32'(resp_bit), 32'(r.rbit));
      end else begin
        chk("resp_valid_idle", 32'(resp_valid), 32'(exp_rv));
      end
      chk("proto_err", 32'(proto_err), 32'(m_proto));
      chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    end
  end

  initial begin
    int guard;
    // Reset held three cycles with every requester asking.
    k_full = 1'b1;
    repeat (3) do_cycle(1'b1);
    @(posedge CLK);
    #1;
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_resp_bit", 32'(resp_bit), 32'd0);

    // Full load, zero-wait Ini: rotation 0,0,1,1,2,2,3,3,0,...
    repeat (40) do_cycle(1'b0);

    // Mixed random traffic, including timeouts and last-cycle responses.
    k_full = 1'b0; k_valid_pct = 50; k_ready_pct = 50;
    repeat (800) do_cycle(1'b0);

    // Heavy Ini backpressure.
    k_valid_pct = 80; k_ready_pct = 15;
    repeat (300) do_cycle(1'b0);

    // Drain to IDLE, then a response pulse in IDLE must set proto_err.
    k_valid_pct = 0; k_ready_pct = 100;
    guard = 0;
    while (m_busy && guard < 200) begin
      do_cycle(1'b0);
      guard++;
    end
    chk("drain_to_idle", 32'(m_busy), 32'd0);
    k_force_resp = 1'b1;
    do_cycle(1'b0);
    k_force_resp = 1'b0;

    // Reach ISSUE under backpressure, then reset mid-flight.
    k_valid_pct = 100; k_ready_pct = 0;
    guard = 0;
    while (!(m_busy && !m_sent) && guard < 200) begin
      do_cycle(1'b0);
      guard++;
    end
    chk("reach_issue", 32'(m_busy && !m_sent), 32'd1);
    do_cycle(1'b0);
    do_cycle(1'b1);

    // Random traffic with occasional stray responses.
    k_valid_pct = 60; k_ready_pct = 60; k_proto = 1'b1;
    repeat (400) do_cycle(1'b0);

    // Quiet tail so outstanding work completes.
    k_proto = 1'b0; k_valid_pct = 0; k_ready_pct = 100;
    repeat (90) do_cycle(1'b0);
    @(posedge CLK);
    #2;
    chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
